mac_frame: RTL and testbench

Parametrised multiply-accumulate engine with valid/ready handshakes on both sides. It accumulates a programmable-length frame of operand pairs, in signed or unsigned mode, into a saturating accumulator. It presents one result per frame. It sits between an operand source (FIFO or sample stream) and a result consumer, and supersedes the fixed 8-bit free-running MAC.

---
 rtl/mac_frame.sv | 145 ++++++++++++++
 tb/tb_mac_frame.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_frame.sv
// rtl/mac_frame.sv - framed multiply-accumulate engine with saturating accumulator
// Two-stage pipeline (product, then add) with valid/ready handshakes on both sides.
module mac_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  a_reset,
    input  logic                  signed_mode,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  overflow
);
    localparam int PW = 2*DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_HOLD} state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 mode_q, mode_d;
    logic [PW-1:0]        prod_q, prod_d;
    logic                 prod_vld_q, prod_vld_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;

    logic                 accept;
    logic                 cur_mode;
    logic [LEN_WIDTH-1:0] eff_len;
    logic [LEN_WIDTH-1:0] cnt_inc;
    logic [PW-1:0]        a_ext, b_ext;
    logic [ACC_WIDTH:0]   p_ext, acc_ext, sum;
    logic [ACC_WIDTH-1:0] sat_val;
    logic                 sat_hit;

    // Stage 1: operands use the live mode on a frame's first beat, the latched mode afterwards.
    always_comb begin
        in_ready = ~a_reset & ((state_q == S_IDLE) | (state_q == S_ACCUM));
        accept   = in_valid & in_ready;
        cur_mode = (state_q == S_IDLE) ? signed_mode : mode_q;
        eff_len  = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
        cnt_inc  = cnt_q + 1'b1;
        a_ext    = {{DATA_WIDTH{cur_mode & op_a[DATA_WIDTH-1]}}, op_a};
        b_ext    = {{DATA_WIDTH{cur_mode & op_b[DATA_WIDTH-1]}}, op_b};
    end

    // Stage 2: one guard bit above the accumulator detects wrap in either mode.
    always_comb begin
        p_ext   = {{(ACC_WIDTH+1-PW){mode_q & prod_q[PW-1]}}, prod_q};
        acc_ext = {mode_q & acc_q[ACC_WIDTH-1], acc_q};
        sum     = p_ext + acc_ext;
        sat_hit = 1'b0;
        sat_val = sum[ACC_WIDTH-1:0];
        if (mode_q) begin
            if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
                sat_hit = 1'b1;
                sat_val = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else if (sum[ACC_WIDTH]) begin
            sat_hit = 1'b1;
            sat_val = '1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        mode_d     = mode_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        prod_d     = accept ? PW'(a_ext * b_ext) : prod_q;
        prod_vld_d = accept;
        out_valid  = (state_q == S_HOLD);

        if (prod_vld_q) begin
            acc_d = sat_val;
            ovf_d = ovf_q | sat_hit;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mode_d  = signed_mode;
                    len_d   = eff_len;
                    cnt_d   = LEN_WIDTH'(1);
                    state_d = (eff_len == LEN_WIDTH'(1)) ? S_DRAIN : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last product is in the adder while prod_vld_q is high.
                if (!prod_vld_q) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (a_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            mode_q     <= 1'b0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            mode_q     <= mode_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
        end
    end

    assign result   = acc_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_mac_frame.sv
// tb/tb_mac_frame.sv - randomized bench for mac_frame against an arithmetic reference model
// Two instances (default and 16-bit accumulator) share stimulus.
module tb_mac_frame;
    localparam int DW   = 8;
    localparam int LW   = 8;
    localparam int AW   = 24;
    localparam int AW16 = 16;

    logic          clk = 1'b0;
    logic          a_reset = 1'b1;
    logic          signed_mode = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] op_a = '0;
    logic [DW-1:0] op_b = '0;

    logic            in_ready, out_valid, overflow;
    logic [AW-1:0]   result;
    logic            in_ready16, out_valid16, overflow16;
    logic [AW16-1:0] result16;

    int checks = 0;
    int passed = 0;

    logic [DW-1:0] a_q[$];
    logic [DW-1:0] b_q[$];

    mac_frame #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .a_reset(a_reset), .signed_mode(signed_mode), .frame_len(frame_len),
        .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .overflow(overflow)
    );

    mac_frame #(.DATA_WIDTH(DW), .ACC_WIDTH(AW16), .LEN_WIDTH(LW)) dut16 (
        .clk(clk), .a_reset(a_reset), .signed_mode(signed_mode), .frame_len(frame_len),
        .in_valid(in_valid), .in_ready(in_ready16), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid16), .out_ready(out_ready), .result(result16), .overflow(overflow16)
    );

    always #5 clk = ~clk;

    function automatic void model(input bit mode, input int n, input int aw,
                                  output longint res, output bit ovf);
        longint mx, mn, p;
        res = 0;
        ovf = 1'b0;
        mx  = mode ? (longint'(1) <<< (aw-1)) - 1 : (longint'(1) <<< aw) - 1;
        mn  = mode ? -(longint'(1) <<< (aw-1)) : 0;
        for (int i = 0; i < n; i++) begin
            if (mode) p = longint'($signed(a_q[i])) * longint'($signed(b_q[i]));
            else      p = longint'(a_q[i]) * longint'(b_q[i]);
            res += p;
            if (res > mx) begin
                res = mx;
                ovf = 1'b1;
            end else if (res < mn) begin
                res = mn;
                ovf = 1'b1;
            end
        end
    endfunction

    // Drives one frame from a_q/b_q, checks latency, result, backpressure and handshake.
    task automatic do_frame(input string nm, input bit mode, input int flen, input bit gaps,
                            input int hold,
                            output logic [AW-1:0] r24, output logic o24,
                            output logic [AW16-1:0] r16, output logic o16);
        int     len, k, guard;
        bit     acc_now;
        longint m24, m16;
        bit     mo24, mo16;
        len   = (flen == 0) ? 1 : flen;
        k     = 0;
        guard = 0;
        model(mode, len, AW, m24, mo24);
        model(mode, len, AW16, m16, mo16);
        while (k < len && guard < 200) begin
            if (k == 0) begin
                signed_mode = mode;
                frame_len   = LW'(flen);
            end else begin
                signed_mode = 1'($urandom);
                frame_len   = LW'($urandom);
            end
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                op_a     = DW'($urandom);
                op_b     = DW'($urandom);
            end else begin
                in_valid = 1'b1;
                op_a     = a_q[k];
                op_b     = b_q[k];
            end
            acc_now = in_valid && in_ready && in_ready16;
            @(posedge clk); #1;
            if (acc_now) k++;
            guard++;
        end
        in_valid = 1'b0;
        checks++;
        if (k != len) $display("FAIL %s accept_timeout: accepted %0d want %0d", nm, k, len);
        else passed++;

        checks++;
        if (out_valid !== 1'b0 || out_valid16 !== 1'b0 || in_ready !== 1'b0 || in_ready16 !== 1'b0)
            $display("FAIL %s drain1: out_valid %b/%b in_ready %b/%b want 0", nm, out_valid, out_valid16, in_ready, in_ready16);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_valid16 !== 1'b0 || in_ready !== 1'b0 || in_ready16 !== 1'b0)
            $display("FAIL %s drain2: out_valid %b/%b in_ready %b/%b want 0", nm, out_valid, out_valid16, in_ready, in_ready16);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_valid16 !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL %s latency: out_valid %b/%b in_ready %b want 1/1/0", nm, out_valid, out_valid16, in_ready);
        else passed++;
        checks++;
        if (result !== m24[AW-1:0] || overflow !== mo24)
            $display("FAIL %s result24: got %h/%b want %h/%b", nm, result, overflow, m24[AW-1:0], mo24);
        else passed++;
        checks++;
        if (result16 !== m16[AW16-1:0] || overflow16 !== mo16)
            $display("FAIL %s result16: got %h/%b want %h/%b", nm, result16, overflow16, m16[AW16-1:0], mo16);
        else passed++;
        r24 = result;
        o24 = overflow;
        r16 = result16;
        o16 = overflow16;

        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            op_a     = DW'($urandom);
            op_b     = DW'($urandom);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== m24[AW-1:0] ||
                overflow !== mo24 || result16 !== m16[AW16-1:0])
                $display("FAIL %s hold%0d: out_valid %b in_ready %b result %h want 1/0/%h", nm, i, out_valid, in_ready, result, m24[AW-1:0]);
            else passed++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_valid16 !== 1'b0 || in_ready !== 1'b1 || in_ready16 !== 1'b1 ||
            overflow !== 1'b0 || overflow16 !== 1'b0)
            $display("FAIL %s handshake: out_valid %b in_ready %b overflow %b want 0/1/0", nm, out_valid, in_ready, overflow);
        else passed++;
    endtask

    task automatic test_reset();
        a_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || in_ready16 !== 1'b0 || out_valid !== 1'b0 || result !== '0 || overflow !== 1'b0)
            $display("FAIL reset_state: in_ready %b out_valid %b result %h overflow %b want 0/0/0/0", in_ready, out_valid, result, overflow);
        else passed++;
        a_reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || in_ready16 !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_release: in_ready %b out_valid %b want 1/0", in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_unsigned3();
        logic [AW-1:0] r24; logic o24; logic [AW16-1:0] r16; logic o16;
        a_q = '{8'h0F, 8'h26, 8'h03};
        b_q = '{8'h1A, 8'h05, 8'h11};
        do_frame("unsigned3", 1'b0, 3, 1'b0, 0, r24, o24, r16, o16);
        checks++;
        if (r24 !== 24'h000277 || o24 !== 1'b0)
            $display("FAIL unsigned3_const: got %h/%b want 000277/0", r24, o24);
        else passed++;
    endtask

    task automatic test_signed_vs_unsigned();
        logic [AW-1:0] r24; logic o24; logic [AW16-1:0] r16; logic o16;
        a_q = '{8'hFF, 8'h03};
        b_q = '{8'h02, 8'h04};
        do_frame("signed2", 1'b1, 2, 1'b0, 0, r24, o24, r16, o16);
        checks++;
        if (r24 !== 24'h00000A) $display("FAIL signed2_const: got %h want 00000a", r24);
        else passed++;
        do_frame("unsigned2", 1'b0, 2, 1'b0, 0, r24, o24, r16, o16);
        checks++;
        if (r24 !== 24'h00020A) $display("FAIL unsigned2_const: got %h want 00020a", r24);
        else passed++;
    endtask

    task automatic test_saturation();
        logic [AW-1:0] r24; logic o24; logic [AW16-1:0] r16; logic o16;
        a_q = '{8'hFF, 8'hFF};
        b_q = '{8'hFF, 8'hFF};
        do_frame("sat_unsigned", 1'b0, 2, 1'b0, 0, r24, o24, r16, o16);
        checks++;
        if (r16 !== 16'hFFFF || o16 !== 1'b1 || r24 !== 24'h01FC02 || o24 !== 1'b0)
            $display("FAIL sat_unsigned_const: got %h/%b %h/%b want ffff/1 01fc02/0", r16, o16, r24, o24);
        else passed++;
        a_q = '{8'h80, 8'h80, 8'h80};
        b_q = '{8'h80, 8'h80, 8'h80};
        do_frame("sat_signed", 1'b1, 3, 1'b0, 0, r24, o24, r16, o16);
        checks++;
        if (r16 !== 16'h7FFF || o16 !== 1'b1 || r24 !== 24'h00C000 || o24 !== 1'b0)
            $display("FAIL sat_signed_const: got %h/%b %h/%b want 7fff/1 00c000/0", r16, o16, r24, o24);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] r24; logic o24; logic [AW16-1:0] r16; logic o16;
        a_q = '{8'h11, 8'h22, 8'h33};
        b_q = '{8'h44, 8'h55, 8'h66};
        do_frame("backpressure", 1'b0, 3, 1'b0, 5, r24, o24, r16, o16);
    endtask

    task automatic test_gapped_len0();
        logic [AW-1:0] r24; logic o24; logic [AW16-1:0] r16; logic o16;
        a_q = '{8'h05};
        b_q = '{8'h06};
        do_frame("len0", 1'b0, 0, 1'b0, 0, r24, o24, r16, o16);
        checks++;
        if (r24 !== 24'd30) $display("FAIL len0_const: got %0d want 30", r24);
        else passed++;
        a_q.delete();
        b_q.delete();
        for (int i = 0; i < 4; i++) begin
            a_q.push_back(DW'($urandom));
            b_q.push_back(DW'($urandom));
        end
        do_frame("gapped4", 1'b1, 4, 1'b1, 1, r24, o24, r16, o16);
    endtask

    task automatic test_reset_midframe();
        logic [AW-1:0] r24; logic o24; logic [AW16-1:0] r16; logic o16;
        signed_mode = 1'b0;
        frame_len   = LW'(3);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            op_a     = 8'h40 + DW'(i);
            op_b     = 8'h21;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        a_reset  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) $display("FAIL midreset_inready: got %b want 0", in_ready);
        else passed++;
        @(posedge clk); #1;
        a_reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== '0 || overflow !== 1'b0 || in_ready !== 1'b1 || result16 !== '0)
            $display("FAIL midreset_state: out_valid %b result %h overflow %b in_ready %b want 0/0/0/1", out_valid, result, overflow, in_ready);
        else passed++;
        a_q = '{8'h02};
        b_q = '{8'h03};
        do_frame("after_reset", 1'b0, 1, 1'b0, 0, r24, o24, r16, o16);
        checks++;
        if (r24 !== 24'd6) $display("FAIL after_reset_const: got %0d want 6", r24);
        else passed++;
    endtask

    task automatic test_random();
        logic [AW-1:0] r24; logic o24; logic [AW16-1:0] r16; logic o16;
        int flen, n;
        for (int f = 0; f < 40; f++) begin
            flen = $urandom_range(0, 6);
            n    = (flen == 0) ? 1 : flen;
            a_q.delete();
            b_q.delete();
            for (int i = 0; i < n; i++) begin
                a_q.push_back(DW'($urandom));
                b_q.push_back(DW'($urandom));
            end
            do_frame($sformatf("random%0d", f), 1'($urandom), flen, 1'($urandom),
                     $urandom_range(0, 3), r24, o24, r16, o16);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_unsigned3();
        test_signed_vs_unsigned();
        test_saturation();
        test_backpressure();
        test_gapped_len0();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
